// File: rtl/scan_harness.sv
// Serial scan validation wrapper around a crypto core: loads a stimulus vector, launches it
// with single-cycle pulses, measures core latency and captures the result for serial unload.
module scan_harness #(
   parameter int IN_W       = 168,
   parameter int OUT_W      = 32,
   parameter int CNT_W      = 16,
   parameter int PULSE_BITS = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             scan_en,
   input  logic             scan_in,
   input  logic             begin_validate,
   output logic             scan_out,
   output logic             busy,
   input  logic [IN_W-1:0]  func_in,
   output logic [IN_W-1:0]  core_in,
   input  logic [OUT_W-1:0] core_out,
   input  logic             core_done,
   output logic [OUT_W-1:0] func_out,
   output logic             func_done
);

   localparam int SO_W = OUT_W + CNT_W + 2;
   localparam logic [IN_W-1:0] PULSE_MASK = {{PULSE_BITS{1'b0}}, {(IN_W-PULSE_BITS){1'b1}}};
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [2:0] {IDLE, LOAD, LAUNCH, RUN, HOLD} state_t;

   state_t            state;
   logic [IN_W-1:0]   in_chain;
   logic [SO_W-1:0]   out_chain;
   logic [CNT_W-1:0]  cnt;

   // Dropping begin_validate aborts everything and keeps both chains; in IDLE the in-chain
   // still shifts so a vector can be preloaded before the session starts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         in_chain  <= '0;
         out_chain <= '0;
         cnt       <= '0;
      end else if (!begin_validate) begin
         if (state == IDLE && scan_en)
            in_chain <= {in_chain[IN_W-2:0], scan_in};
         state <= IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (scan_en)
                  in_chain <= {in_chain[IN_W-2:0], scan_in};
               state <= LOAD;
            end
            LOAD: begin
               if (scan_en) begin
                  in_chain <= {in_chain[IN_W-2:0], scan_in};
               end else begin
                  cnt   <= '0;
                  state <= LAUNCH;
               end
            end
            // The LAUNCH cycle is latency index 0, so a done seen there captures cnt=0.
            LAUNCH, RUN: begin
               if (core_done) begin
                  out_chain <= {1'b0, 1'b1, cnt, core_out};
                  state     <= HOLD;
               end else if (cnt == CNT_MAX) begin
                  out_chain <= {1'b1, 1'b0, cnt, core_out};
                  state     <= HOLD;
               end else begin
                  cnt   <= cnt + 1'b1;
                  state <= RUN;
               end
            end
            HOLD: begin
               if (scan_en) begin
                  in_chain  <= {in_chain[IN_W-2:0], scan_in};
                  out_chain <= {out_chain[SO_W-2:0], 1'b0};
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Pins see the core directly only in IDLE; pulses reach the core unmasked only in LAUNCH.
   always_comb begin
      core_in   = in_chain & PULSE_MASK;
      func_out  = '0;
      func_done = 1'b0;
      if (state == IDLE) begin
         core_in   = func_in;
         func_out  = core_out;
         func_done = core_done;
      end else if (state == LAUNCH) begin
         core_in = in_chain;
      end
   end

   assign busy     = (state == LAUNCH) || (state == RUN);
   assign scan_out = (state == HOLD) && scan_en && out_chain[SO_W-1];

endmodule

// File: tb/tb_scan_harness.sv
// Self-checking bench for scan_harness: directed scenarios plus randomized vectors and
// latencies, checked against a latency/timeout model derived from the capture rules.
module tb_scan_harness;

   localparam int IN_W  = 8;
   localparam int OUT_W = 4;
   localparam int CNT_W = 4;
   localparam int PB    = 1;
   localparam int SO_W  = OUT_W + CNT_W + 2;
   localparam int MAXC  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             scan_en;
   logic             scan_in;
   logic             begin_validate;
   logic             scan_out;
   logic             busy;
   logic [IN_W-1:0]  func_in;
   logic [IN_W-1:0]  core_in;
   logic [OUT_W-1:0] core_out;
   logic             core_done;
   logic [OUT_W-1:0] func_out;
   logic             func_done;

   int checks = 0;
   int errors = 0;
   logic [IN_W-1:0] model_in;
   logic [IN_W-1:0] pulse_mask;

   scan_harness #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W), .PULSE_BITS(PB)) dut (
      .clk(clk), .rst(rst), .scan_en(scan_en), .scan_in(scan_in),
      .begin_validate(begin_validate), .scan_out(scan_out), .busy(busy),
      .func_in(func_in), .core_in(core_in), .core_out(core_out), .core_done(core_done),
      .func_out(func_out), .func_done(func_done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic bv, input logic se, input logic si);
      begin_validate = bv;
      scan_en        = se;
      scan_in        = si;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Shift a whole vector MSB-first starting from IDLE; the entry edge itself shifts one bit.
   task automatic shiftIn(input logic [IN_W-1:0] vec);
      for (int i = 0; i < IN_W; i++) begin
         applyStimulus(1'b1, 1'b1, vec[IN_W-1-i]);
         cycle();
      end
      model_in = vec;
      checkOutput("load_busy", 32'(busy), 32'd0);
      checkOutput("load_core_in", 32'(core_in), 32'(model_in & pulse_mask));
      applyStimulus(1'b1, 1'b0, 1'b0);
      cycle();
   endtask

   // Enters mid-cycle in LAUNCH; drives done at index lat (never if lat > MAXC), unloads, exits to IDLE.
   task automatic runFromLaunch(input int lat, input logic [OUT_W-1:0] data);
      int last;
      int timeout;
      int word;
      logic si;
      timeout = (lat > MAXC) ? 1 : 0;
      last    = timeout ? MAXC : lat;
      for (int idx = 0; idx <= last; idx++) begin
         core_out  = (idx == last) ? data : OUT_W'($urandom);
         core_done = (idx == lat);
         #1;
         checkOutput("run_busy", 32'(busy), 32'd1);
         checkOutput(idx == 0 ? "launch_core_in" : "run_core_in", 32'(core_in),
                     32'(idx == 0 ? model_in : (model_in & pulse_mask)));
         checkOutput("run_func_out", {27'd0, func_done, func_out}, 32'd0);
         cycle();
      end
      core_done = 1'b0;
      #1;
      checkOutput("hold_busy", 32'(busy), 32'd0);
      checkOutput("hold_core_in", 32'(core_in), 32'(model_in & pulse_mask));
      checkOutput("hold_idle_scan_out", 32'(scan_out), 32'd0);
      word = timeout * (1 << (SO_W-1)) + (1 - timeout) * (1 << (SO_W-2))
             + last * (1 << OUT_W) + int'(data);
      for (int b = 0; b < SO_W; b++) begin
         si = 1'($urandom);
         applyStimulus(1'b1, 1'b1, si);
         #1;
         checkOutput("unload_bit", 32'(scan_out), 32'((word >> (SO_W-1-b)) & 1));
         model_in = {model_in[IN_W-2:0], si};
         cycle();
      end
      #1;
      checkOutput("unload_zero_fill", 32'(scan_out), 32'd0);
      checkOutput("hold_no_relaunch", 32'(busy), 32'd0);
      checkOutput("hold_in_shift", 32'(core_in), 32'(model_in & pulse_mask));
      applyStimulus(1'b0, 1'b0, 1'b0);
      cycle();
   endtask

   initial begin
      pulse_mask = {{PB{1'b0}}, {(IN_W-PB){1'b1}}};
      model_in   = '0;
      rst        = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0);
      func_in    = 8'hA5;
      core_out   = 4'h9;
      core_done  = 1'b1;
      #12;
      checkOutput("reset_core_in", 32'(core_in), 32'hA5);
      checkOutput("reset_func_out", 32'(func_out), 32'h9);
      checkOutput("reset_func_done", 32'(func_done), 32'd1);
      checkOutput("reset_scan_out", 32'(scan_out), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      cycle();
      rst       = 1'b0;
      core_done = 1'b0;
      #1;
      checkOutput("func_done_low", 32'(func_done), 32'd0);

      // Directed: 8'h81, done at index 5 with data C.
      shiftIn(8'h81);
      runFromLaunch(5, 4'hC);

      // Directed: timeout, then done during LAUNCH.
      shiftIn(8'h3C);
      runFromLaunch(MAXC + 4, 4'h6);
      shiftIn(8'hF0);
      runFromLaunch(0, 4'hA);
      shiftIn(8'h5A);
      runFromLaunch(MAXC, 4'h3);

      // Abort at RUN index 3 while done rises: abort wins, in-chain retained.
      shiftIn(8'hC7);
      for (int idx = 0; idx < 3; idx++) begin
         #1;
         checkOutput("abort_pre_busy", 32'(busy), 32'd1);
         cycle();
      end
      core_done = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0);
      cycle();
      func_in  = 8'h3E;
      core_out = 4'h7;
      #1;
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_core_in", 32'(core_in), 32'h3E);
      checkOutput("abort_func_out", 32'(func_out), 32'h7);
      checkOutput("abort_func_done", 32'(func_done), 32'd1);
      core_done = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b0);
      cycle();
      checkOutput("abort_retained", 32'(core_in), 32'(model_in & pulse_mask));
      cycle();
      runFromLaunch(2, 4'hB);

      // Async reset mid-RUN clears state and chains immediately.
      shiftIn(8'hE1);
      cycle();
      cycle();
      #1;
      rst = 1'b1;
      #1;
      checkOutput("rst_run_busy", 32'(busy), 32'd0);
      checkOutput("rst_run_core_in", 32'(core_in), 32'(func_in));
      #1;
      rst = 1'b0;
      model_in = '0;
      cycle();
      applyStimulus(1'b1, 1'b0, 1'b0);
      cycle();
      checkOutput("rst_chain_cleared", 32'(core_in), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      cycle();

      // Randomized vectors, latencies (including timeouts) and data.
      for (int r = 0; r < 12; r++) begin
         shiftIn(IN_W'($urandom));
         runFromLaunch(int'($urandom_range(0, MAXC + 4)), OUT_W'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/scan_harness.md
# scan_harness

Parametrised serial scan-based validation wrapper that sits between chip pins and a crypto core (keygen/algo pair or any successor engine). It loads a stimulus vector serially, launches it into the core with single-cycle pulse inputs, and measures the core's latency in clock cycles. It captures the core's result, done status and a timeout flag into an output chain for serial unload. In functional mode it is a transparent passthrough.

## Interface
Parameters:
- IN_W, 168, width of stimulus vector / core input bundle.
- OUT_W, 32, width of core result.
- CNT_W, 16, width of latency counter.
- PULSE_BITS, 3, number of MSBs of the stimulus treated as launch pulses (load/encrypt/decrypt); the rest are static levels.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock; reset is asynchronous and active-high.
- scan_en  in  1  shift enable for both chains.
- scan_in  in  1  serial stimulus bit, shifted into chain LSB.
- begin_validate  in  1  validation session enable; low = functional mode.
- scan_out  out  1  serial result bit (MSB of output chain).
- busy  out  1  high in LAUNCH and RUN.
- func_in  in  IN_W  functional-mode core inputs from pins.
- core_in  out  IN_W  inputs driven to the core.
- core_out  in  OUT_W  core result.
- core_done  in  1  core completion flag.
- func_out  out  OUT_W  result to pins.
- func_done  out  1  done to pins.

## Operation
- In-chain: IN_W bits, shifts left, scan_in enters bit 0; takes the first bit shifted in to the MSB after IN_W shifts.
- Out-chain: SO_W = OUT_W+CNT_W+2 bits = {timeout, done_seen, cnt, data}. Shifts left, zero fill.
- FSM states: IDLE, LOAD, LAUNCH, RUN, HOLD.
- IDLE: core_in=func_in, func_out=core_out, func_done=core_done (combinational). scan_en shifts in-chain. begin_validate=1 -> LOAD.
- LOAD: scan_en=1 shifts in-chain. scan_en=0 -> LAUNCH.
- LAUNCH, one cycle: core_in = in-chain unmasked. cnt=0.
- RUN: core_in = in-chain with top PULSE_BITS forced 0. scan_en ignored.
- Done detection in LAUNCH or RUN: on an edge with core_done=1, load out-chain {0,1,cnt,core_out} -> HOLD.
- Otherwise cnt increments. If cnt==2^CNT_W-1 and core_done=0, load {1,0,cnt,core_out} -> HOLD. Counter never wraps.
- HOLD: core_in stays masked. scan_en shifts both chains, so the next vector loads while the current result unloads. Stays in HOLD until begin_validate=0; no re-launch from HOLD.
- Pulse masking also applies in LOAD and HOLD.
- Any non-IDLE state: func_out=0, func_done=0.
- begin_validate=0 in any state -> IDLE on next edge. This aborts RUN; no capture occurs and both chains are retained.
- scan_out = out-chain MSB when state==HOLD and scan_en=1, else 0.

## Timing
- Reset: state IDLE, both chains 0, cnt 0, scan_out 0, busy 0. core_in/func_out/func_done pass through combinationally.
- Reset mid-RUN returns to IDLE immediately (async).
- Captured latency L = cycles from the LAUNCH cycle (index 0) to the first cycle with core_done=1. core_done high during LAUNCH gives L=0.
- A launch pulse lasts exactly one clk cycle, regardless of how long scan_en stays low.
- Transition to LAUNCH occurs on the first edge in LOAD with scan_en=0.
- Entering HOLD from RUN: scan_out presents the timeout bit on the first HOLD cycle with scan_en=1. SO_W shifts unload all bits.
- Simultaneous begin_validate fall and core_done in RUN: abort wins, no capture.

## Test plan
For these scenarios use IN_W=8, OUT_W=4, CNT_W=4, PULSE_BITS=1.
- Reset then functional mode: func_in=8'hA5 -> core_in=8'hA5; core_out=4'h9, core_done=1 -> func_out=4'h9, func_done=1; scan_out=0.
- Shift 8'h81 MSB-first in LOAD, drop scan_en -> core_in=8'h81 for exactly one cycle, then 8'h01. busy rises the same cycle.
- Core raises core_done at index 5 with core_out=4'hC -> HOLD. 10 scan shifts yield 0,1,0101,1100.
- core_done never rises -> at cnt=15, timeout=1, HOLD. Unload gives 1,0,1111,data.
- begin_validate dropped at RUN index 3, then reasserted with new scan -> IDLE then LOAD. In-chain retained; no capture; func passthrough active while in IDLE.
- core_done=1 during LAUNCH -> captured cnt=0, done_seen=1.
